// File: rtl/nn_pkg.sv
// Shared types and output-stage arithmetic for the dense MAC layer.
// Holds the sequencer state encoding and the saturate/ReLU helper.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MAC    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  // Wide enough for any accumulator this layer is built with.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_relu(
    input logic signed [SAT_W-1:0] val,
    input int                      data_w,
    input bit                      relu_en
  );
    logic signed [SAT_W-1:0] lim_hi;
    logic signed [SAT_W-1:0] lim_lo;
    logic signed [SAT_W-1:0] res;
    lim_hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lim_lo = -(64'sd1 <<< (data_w - 1));
    if (val > lim_hi)      res = lim_hi;
    else if (val < lim_lo) res = lim_lo;
    else                   res = val;
    if (relu_en && res[SAT_W-1]) res = '0;
    return res;
  endfunction

endpackage

// File: rtl/nn_mac.sv
// One neuron accumulator: loads the bias on start, then adds one
// full-precision product per cycle while enabled.
module nn_mac #(
  parameter int DATA_W   = 16,
  parameter int WEIGHT_W = 8,
  parameter int ACC_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_load,
  input  logic                       i_acc_en,
  input  logic signed [WEIGHT_W-1:0] i_bias,
  input  logic signed [DATA_W-1:0]   i_x,
  input  logic signed [WEIGHT_W-1:0] i_w,
  output logic signed [ACC_W-1:0]    o_acc
);

  localparam int PROD_W = DATA_W + WEIGHT_W;

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  r_acc;

  // Both operands widened as signed so the product is exact before extension.
  assign w_prod = PROD_W'(i_x) * PROD_W'(i_w);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc <= '0;
    end else if (i_load) begin
      r_acc <= ACC_W'(i_bias);
    end else if (i_acc_en) begin
      r_acc <= r_acc + ACC_W'(w_prod);
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/dense_mac_layer.sv
// Fully connected layer: NEURON_NB parallel MACs stepped over IN_SIZE inputs,
// followed by shift, saturation, optional ReLU and an argmax of the results.
module dense_mac_layer
  import nn_pkg::*;
#(
  parameter int NEURON_NB = 10,
  parameter int IN_SIZE   = 32,
  parameter int DATA_W    = 16,
  parameter int WEIGHT_W  = 8,
  parameter int ACC_W     = 32,
  parameter int OUT_SHIFT = 0,
  parameter int RELU_EN   = 1,
  localparam int IDX_W    = (NEURON_NB > 1) ? $clog2(NEURON_NB) : 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       layer_en,
  input  logic signed [DATA_W-1:0]   in_data   [0:IN_SIZE-1],
  input  logic signed [WEIGHT_W-1:0] weights   [0:NEURON_NB-1][0:IN_SIZE-1],
  input  logic signed [WEIGHT_W-1:0] biases    [0:NEURON_NB-1],
  output logic signed [DATA_W-1:0]   layer_out [0:NEURON_NB-1],
  output logic                       layer_done,
  output logic                       busy,
  output logic [IDX_W-1:0]           max_idx
);

  localparam int CNT_W = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_SIZE - 1);

  state_t                     r_state;
  logic [CNT_W-1:0]           r_cnt;
  logic                       r_busy;
  logic                       r_done;
  logic [IDX_W-1:0]           r_max_idx;
  logic signed [DATA_W-1:0]   r_layer_out [0:NEURON_NB-1];
  logic signed [DATA_W-1:0]   r_in        [0:IN_SIZE-1];
  logic signed [WEIGHT_W-1:0] r_w         [0:NEURON_NB-1][0:IN_SIZE-1];

  logic                       w_start;
  logic                       w_acc_en;
  logic signed [DATA_W-1:0]   w_x;
  logic signed [ACC_W-1:0]    w_acc     [0:NEURON_NB-1];
  logic signed [ACC_W-1:0]    w_shifted [0:NEURON_NB-1];
  logic signed [DATA_W-1:0]   w_res     [0:NEURON_NB-1];
  logic signed [DATA_W-1:0]   w_max_val;
  logic [IDX_W-1:0]           w_max_idx;

  assign w_start  = (r_state == ST_IDLE) && layer_en;
  assign w_acc_en = (r_state == ST_MAC);
  assign w_x      = r_in[r_cnt];

  // NOTE: operand snapshot registers carry no reset; they are always written
  // at start before being read, so resetting them would only add fan-out.
  always_ff @(posedge clk) begin
    if (w_start) begin
      r_in <= in_data;
      r_w  <= weights;
    end
  end

  for (genvar n = 0; n < NEURON_NB; n++) begin : g_neuron
    nn_mac #(
      .DATA_W   (DATA_W),
      .WEIGHT_W (WEIGHT_W),
      .ACC_W    (ACC_W)
    ) u_mac (
      .clk      (clk),
      .reset_n  (reset_n),
      .i_load   (w_start),
      .i_acc_en (w_acc_en),
      .i_bias   (biases[n]),
      .i_x      (w_x),
      .i_w      (r_w[n][r_cnt]),
      .o_acc    (w_acc[n])
    );
  end

  // NOTE: every variable written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    w_max_idx = '0;
    w_max_val = '0;
    for (int n = 0; n < NEURON_NB; n++) begin
      w_shifted[n] = w_acc[n] >>> OUT_SHIFT;
      w_res[n]     = DATA_W'(sat_relu(SAT_W'(w_shifted[n]), DATA_W, RELU_EN != 0));
    end
    w_max_val = w_res[0];
    // Strict compare keeps the lowest index on ties.
    for (int n = 1; n < NEURON_NB; n++) begin
      if (w_res[n] > w_max_val) begin
        w_max_val = w_res[n];
        w_max_idx = IDX_W'(n);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_max_idx <= '0;
      for (int n = 0; n < NEURON_NB; n++) r_layer_out[n] <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (layer_en) begin
            r_state <= ST_MAC;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        ST_MAC: begin
          if (r_cnt == CNT_LAST) r_state <= ST_FINISH;
          else                   r_cnt   <= r_cnt + CNT_W'(1);
        end
        ST_FINISH: begin
          r_layer_out <= w_res;
          r_max_idx   <= w_max_idx;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign layer_out  = r_layer_out;
  assign layer_done = r_done;
  assign busy       = r_busy;
  assign max_idx    = r_max_idx;

endmodule

// File: tb/tb_dense_mac_layer.sv
// Directed bench for dense_mac_layer: three instances (ReLU, linear, linear
// with shift 2) share stimulus; expected values are hand-computed constants.
module tb_dense_mac_layer;

  localparam int NN = 2;
  localparam int IS = 3;
  localparam int DW = 16;
  localparam int WW = 8;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic reset_n;
  logic layer_en;
  logic signed [DW-1:0] in_data [0:IS-1];
  logic signed [WW-1:0] weights [0:NN-1][0:IS-1];
  logic signed [WW-1:0] biases  [0:NN-1];

  logic signed [DW-1:0] out_r [0:NN-1];
  logic signed [DW-1:0] out_l [0:NN-1];
  logic signed [DW-1:0] out_s [0:NN-1];
  logic done_r, done_l, done_s;
  logic busy_r, busy_l, busy_s;
  logic max_r, max_l, max_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dense_mac_layer #(.NEURON_NB(NN), .IN_SIZE(IS), .DATA_W(DW), .WEIGHT_W(WW),
                    .ACC_W(AW), .OUT_SHIFT(0), .RELU_EN(1)) u_relu (
    .clk(clk), .reset_n(reset_n), .layer_en(layer_en), .in_data(in_data),
    .weights(weights), .biases(biases), .layer_out(out_r),
    .layer_done(done_r), .busy(busy_r), .max_idx(max_r));

  dense_mac_layer #(.NEURON_NB(NN), .IN_SIZE(IS), .DATA_W(DW), .WEIGHT_W(WW),
                    .ACC_W(AW), .OUT_SHIFT(0), .RELU_EN(0)) u_lin (
    .clk(clk), .reset_n(reset_n), .layer_en(layer_en), .in_data(in_data),
    .weights(weights), .biases(biases), .layer_out(out_l),
    .layer_done(done_l), .busy(busy_l), .max_idx(max_l));

  dense_mac_layer #(.NEURON_NB(NN), .IN_SIZE(IS), .DATA_W(DW), .WEIGHT_W(WW),
                    .ACC_W(AW), .OUT_SHIFT(2), .RELU_EN(0)) u_shift (
    .clk(clk), .reset_n(reset_n), .layer_en(layer_en), .in_data(in_data),
    .weights(weights), .biases(biases), .layer_out(out_s),
    .layer_done(done_s), .busy(busy_s), .max_idx(max_s));

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_vec(input int x0, input int x1, input int x2,
                         input int w00, input int w01, input int w02,
                         input int w10, input int w11, input int w12,
                         input int b0, input int b1);
    in_data[0] = DW'(x0); in_data[1] = DW'(x1); in_data[2] = DW'(x2);
    weights[0][0] = WW'(w00); weights[0][1] = WW'(w01); weights[0][2] = WW'(w02);
    weights[1][0] = WW'(w10); weights[1][1] = WW'(w11); weights[1][2] = WW'(w12);
    biases[0] = WW'(b0); biases[1] = WW'(b1);
  endtask

  // Garbage applied right after the start edge must not disturb the run.
  task automatic scramble();
    for (int i = 0; i < IS; i++) in_data[i] = DW'($urandom);
    for (int n = 0; n < NN; n++) begin
      biases[n] = WW'($urandom);
      for (int i = 0; i < IS; i++) weights[n][i] = WW'($urandom);
    end
  endtask

  task automatic check_out(input string tag, input int r0, input int r1,
                           input int l0, input int l1, input int s0, input int s1,
                           input int m);
    check({tag, "_relu0"}, out_r[0], r0);
    check({tag, "_relu1"}, out_r[1], r1);
    check({tag, "_lin0"},  out_l[0], l0);
    check({tag, "_lin1"},  out_l[1], l1);
    check({tag, "_shf0"},  out_s[0], s0);
    check({tag, "_shf1"},  out_s[1], s1);
    check({tag, "_max_relu"}, max_r, m);
    check({tag, "_max_lin"},  max_l, m);
    check({tag, "_max_shf"},  max_s, m);
  endtask

  // Pulse start, then count negedges until layer_done (bounded).
  task automatic run(input string tag);
    int lat;
    logic busy_seen;
    lat = -1;
    busy_seen = 1'b0;
    @(negedge clk); layer_en = 1'b1;
    @(negedge clk); layer_en = 1'b0; scramble();
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(negedge clk);
      if (c == 1) busy_seen = busy_r;
      if (done_r) lat = c;
    end
    check({tag, "_latency"}, lat, 4);
    check({tag, "_busy"}, busy_seen, 1);
    check({tag, "_done_all"}, done_l && done_s, 1);
  endtask

  initial begin
    int pulses;
    int last_cyc;
    int dcount;

    reset_n  = 1'b0;
    layer_en = 1'b0;
    set_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    check("rst_out0", out_r[0], 0);
    check("rst_out1", out_l[1], 0);
    check("rst_done", done_r, 0);
    check("rst_busy", busy_r, 0);
    check("rst_max",  max_r, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic: 6 and -6
    set_vec(1, 2, 3, 1, 1, 1, -1, -1, -1, 0, 0);
    run("basic");
    check_out("basic", 6, 0, 6, -6, 1, -2, 0);
    @(negedge clk);
    check("basic_pulse_width", done_r, 0);
    check("basic_idle_busy", busy_r, 0);

    // Biases, winner at index 1: -4 and 5
    set_vec(1, 2, 3, 1, 1, 1, 1, 0, 0, -10, 4);
    run("bias");
    check_out("bias", 0, 5, -4, 5, -1, 1, 1);

    // Tie {5,5} with a start request while busy
    set_vec(1, 2, 2, 1, 1, 1, 1, 1, 1, 0, 0);
    @(negedge clk); layer_en = 1'b1;
    @(negedge clk); layer_en = 1'b0; scramble();
    @(negedge clk); layer_en = 1'b1;
    @(negedge clk); layer_en = 1'b0;
    dcount = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done_r) dcount++;
    end
    check("tie_done_count", dcount, 1);
    check_out("tie", 5, 5, 5, 5, 1, 1, 0);

    // Positive saturation
    set_vec(32767, 32767, 32767, 127, 127, 127, 127, 127, 127, 0, 0);
    run("satp");
    check_out("satp", 32767, 32767, 32767, 32767, 32767, 32767, 0);

    // Negative saturation on neuron 0, positive on neuron 1
    set_vec(-32768, -32768, -32768, 127, 127, 127, -127, -127, -127, 0, 0);
    run("satn");
    check_out("satn", 0, 32767, -32768, 32767, -32768, 32767, 1);
    repeat (6) @(negedge clk);
    check("hold_lin0", out_l[0], -32768);
    check("hold_max",  max_l, 1);

    // Back-to-back with layer_en held; alternate basic / bias vectors
    set_vec(1, 2, 3, 1, 1, 1, -1, -1, -1, 0, 0);
    @(negedge clk); layer_en = 1'b1;
    pulses = 0;
    last_cyc = 0;
    for (int c = 1; c <= 40 && pulses < 4; c++) begin
      @(negedge clk);
      if (done_l) begin
        pulses++;
        check($sformatf("b2b%0d_gap", pulses), c - last_cyc, 5);
        last_cyc = c;
        if (pulses % 2 == 1) begin
          check($sformatf("b2b%0d_lin0", pulses), out_l[0], 6);
          check($sformatf("b2b%0d_lin1", pulses), out_l[1], -6);
          set_vec(1, 2, 3, 1, 1, 1, 1, 0, 0, -10, 4);
        end else begin
          check($sformatf("b2b%0d_lin0", pulses), out_l[0], -4);
          check($sformatf("b2b%0d_relu1", pulses), out_r[1], 5);
          set_vec(1, 2, 3, 1, 1, 1, -1, -1, -1, 0, 0);
        end
        if (pulses == 4) layer_en = 1'b0;
      end
    end
    layer_en = 1'b0;
    check("b2b_pulses", pulses, 4);
    repeat (3) @(negedge clk);
    check("b2b_stopped", busy_r, 0);

    // Reset in the middle of MAC
    set_vec(1, 2, 3, 1, 1, 1, -1, -1, -1, 0, 0);
    @(negedge clk); layer_en = 1'b1;
    @(negedge clk); layer_en = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("abort_relu1", out_r[1], 0);
    check("abort_lin0",  out_l[0], 0);
    check("abort_max",   max_l, 0);
    check("abort_busy",  busy_r, 0);
    check("abort_done",  done_r, 0);
    @(negedge clk); reset_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done_r || done_l || done_s) dcount++;
    end
    check("abort_no_done", dcount, 0);
    set_vec(1, 2, 3, 1, 1, 1, -1, -1, -1, 0, 0);
    run("after_rst");
    check_out("after_rst", 6, 0, 6, -6, 1, -2, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
